bcd_a_binario: RTL and testbench

- Sequential BCD-to-binary converter. It is the inverse path of the team's binary-to-BCD display translator.
- Accepts N_DIGITS BCD digits serially, most-significant digit first, over a valid/ready handshake.
- Accumulates value = value*10 + digit and presents the binary result with a one-cycle valid pulse.
- Sits between the digit-entry front end (switches/keypad) and the pulse counter's preset/compare input.

---
 rtl/bcd_a_binario_pkg.sv | 19 +
 rtl/bcd_mul10_sum.sv | 24 ++
 rtl/bcd_a_binario.sv | 128 ++++++++++++
 tb/tb_bcd_a_binario.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_a_binario_pkg.sv
// Shared definitions for the serial BCD-to-binary converter.
package bcd_a_binario_pkg;

    localparam int WIDTH_DEF    = 5;
    localparam int N_DIGITS_DEF = 2;
    localparam int BCD_MAX      = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no digits taken yet
        ACUM = 2'd1,  // at least one digit taken
        DONE = 2'd2   // result presenting, one bubble cycle
    } state_t;

    // Largest value representable in a w-bit result.
    function automatic int unsigned max_val(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/bcd_mul10_sum.sv
// Combinational step of the conversion: nxt = acc*10 + digit, with flags.
module bcd_mul10_sum
    import bcd_a_binario_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH+3:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [WIDTH+3:0] nxt_o,
    output logic             ovf_o,
    output logic             bad_digit_o
);

    localparam int AW = WIDTH + 4;
    localparam logic [AW-1:0] MAX_VAL = AW'(max_val(WIDTH));

    // acc never exceeds MAX_VAL, so acc*10 + 15 always fits in AW bits.
    always_comb begin
        nxt_o       = (acc_i << 3) + (acc_i << 1) + {{(AW-4){1'b0}}, digit_i};
        ovf_o       = (nxt_o > MAX_VAL);
        bad_digit_o = (digit_i > 4'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_a_binario.sv
// Serial BCD-to-binary converter: N_DIGITS digits, MSD first, valid/ready in,
// one-cycle valid pulse out with held result and error flag.
module bcd_a_binario
    import bcd_a_binario_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int N_DIGITS = N_DIGITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Limpiar,
    input  logic [3:0]       Digito,
    input  logic             Digito_valido,
    output logic             Digito_listo,
    output logic [WIDTH-1:0] Cuenta,
    output logic             Cuenta_valida,
    output logic             Error
);

    localparam int AW = WIDTH + 4;
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] LAST    = CW'(N_DIGITS - 1);
    localparam logic [AW-1:0] MAX_ACC = AW'(max_val(WIDTH));

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_bcd_q, err_bcd_d;
    logic              err_ovf_q, err_ovf_d;
    logic [WIDTH-1:0]  cuenta_q, cuenta_d;
    logic              error_q, error_d;
    logic              valida_q, valida_d;

    logic [AW-1:0]     nxt;
    logic              ovf;
    logic              bad_digit;
    logic              accept;
    logic              any_err;

    bcd_mul10_sum #(.WIDTH(WIDTH)) u_mul10_sum (
        .acc_i       (acc_q),
        .digit_i     (Digito),
        .nxt_o       (nxt),
        .ovf_o       (ovf),
        .bad_digit_o (bad_digit)
    );

    assign Digito_listo  = (state_q != DONE);
    assign accept        = Digito_valido && Digito_listo;
    assign any_err       = err_bcd_q | err_ovf_q | bad_digit | ovf;
    assign Cuenta        = cuenta_q;
    assign Error         = error_q;
    assign Cuenta_valida = valida_q;

    // Next-state, accumulator and result logic.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        err_bcd_d = err_bcd_q;
        err_ovf_d = err_ovf_q;
        cuenta_d  = cuenta_q;
        error_d   = error_q;
        valida_d  = 1'b0;

        if (Limpiar) begin
            // Abort drops any digit offered on the same edge; result is kept.
            state_d   = IDLE;
            acc_d     = '0;
            cnt_d     = '0;
            err_bcd_d = 1'b0;
            err_ovf_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACUM: begin
                    if (accept) begin
                        if (cnt_q == LAST) begin
                            cuenta_d  = any_err ? {WIDTH{1'b1}} : nxt[WIDTH-1:0];
                            error_d   = any_err;
                            valida_d  = 1'b1;
                            state_d   = DONE;
                            acc_d     = '0;
                            cnt_d     = '0;
                            err_bcd_d = 1'b0;
                            err_ovf_d = 1'b0;
                        end else begin
                            // Clamp on overflow so the accumulator never wraps.
                            acc_d     = ovf ? MAX_ACC : nxt;
                            err_bcd_d = err_bcd_q | bad_digit;
                            err_ovf_d = err_ovf_q | ovf;
                            cnt_d     = cnt_q + CW'(1);
                            state_d   = ACUM;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            err_bcd_q <= 1'b0;
            err_ovf_q <= 1'b0;
            cuenta_q  <= '0;
            error_q   <= 1'b0;
            valida_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            err_bcd_q <= err_bcd_d;
            err_ovf_q <= err_ovf_d;
            cuenta_q  <= cuenta_d;
            error_q   <= error_d;
            valida_q  <= valida_d;
        end
    end

endmodule

// File: tb/tb_bcd_a_binario.sv
// Scoreboard bench for bcd_a_binario: stimulus pushes expected results,
// a negedge monitor pops and compares on every Cuenta_valida pulse.
module tb_bcd_a_binario;

    localparam int WIDTH    = 5;
    localparam int N_DIGITS = 2;
    localparam int MAXV     = (1 << WIDTH) - 1;

    typedef struct {
        int cuenta;
        int err;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             Limpiar;
    logic [3:0]       Digito;
    logic             Digito_valido;
    logic             Digito_listo;
    logic [WIDTH-1:0] Cuenta;
    logic             Cuenta_valida;
    logic             Error;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    bcd_a_binario #(.WIDTH(WIDTH), .N_DIGITS(N_DIGITS)) dut (
        .clk           (clk),
        .rst           (rst),
        .Limpiar       (Limpiar),
        .Digito        (Digito),
        .Digito_valido (Digito_valido),
        .Digito_listo  (Digito_listo),
        .Cuenta        (Cuenta),
        .Cuenta_valida (Cuenta_valida),
        .Error         (Error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (Cuenta_valida === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("cuenta", int'(Cuenta), e.cuenta);
                check("error", int'(Error), e.err);
                check("pulse_cycle", cyc, e.cyc);
                check("listo_in_done", int'(Digito_listo), 0);
            end
        end
    end

    // Reference: decimal value of the digit string; error if any digit is not
    // BCD or the value does not fit in WIDTH bits.
    function automatic exp_t model(input int d0, input int d1);
        exp_t e;
        int   v;
        v     = d0 * 10 + d1;
        e.err = (d0 > 9 || d1 > 9 || v > MAXV) ? 1 : 0;
        e.cuenta = e.err ? MAXV : v;
        e.cyc = 0;
        return e;
    endfunction

    task automatic idle(input int n);
        Digito_valido = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one digit and hold it until an edge accepts it (bounded).
    task automatic send_digit(input int d, output int waits);
        int n;
        n = 0;
        Digito        = 4'(d);
        Digito_valido = 1'b1;
        @(negedge clk);
        while (Digito_listo !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (Digito_listo !== 1'b1) check("listo_timeout", 0, 1);
        @(posedge clk);
        #1;
        waits = n;
    endtask

    // One full conversion; returns stall cycles seen before the first digit.
    task automatic convert(input int d0, input int d1, input bit gaps,
                           output int first_wait);
        exp_t e;
        int   w;
        e = model(d0, d1);
        if (gaps) idle($urandom_range(0, 2));
        send_digit(d0, first_wait);
        if (gaps) idle($urandom_range(0, 2));
        send_digit(d1, w);
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    int w;
    int d0, d1;

    initial begin
        rst           = 1'b1;
        Limpiar       = 1'b0;
        Digito        = 4'd0;
        Digito_valido = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cuenta", int'(Cuenta), 0);
        check("rst_error", int'(Error), 0);
        check("rst_valida", int'(Cuenta_valida), 0);
        check("rst_listo", int'(Digito_listo), 1);
        rst = 1'b0;
        idle(1);

        // Directed conversions.
        convert(2, 7, 0, w);  idle(2);
        convert(3, 1, 0, w);  idle(2);
        convert(3, 2, 0, w);  idle(2);
        convert(9, 9, 0, w);  idle(2);
        convert(1, 12, 0, w); idle(2);
        convert(0, 5, 0, w);  idle(2);
        convert(0, 0, 0, w);  idle(2);
        convert(0, 5, 0, w);  idle(2);

        // Abort after one digit, with a digit offered on the abort edge.
        send_digit(2, w);
        Limpiar       = 1'b1;
        Digito        = 4'd8;
        Digito_valido = 1'b1;
        @(posedge clk);
        #1;
        Limpiar = 1'b0;
        idle(0);
        check("abort_cuenta_kept", int'(Cuenta), 5);
        check("abort_error_kept", int'(Error), 0);
        check("abort_listo", int'(Digito_listo), 1);
        convert(0, 8, 0, w);  idle(2);

        // Streaming with valid held high: one stall between conversions.
        convert(1, 4, 0, w);
        convert(2, 0, 0, w);
        check("stream_stall", w, 1);
        idle(2);

        // Exhaustive sweep of the representable range.
        for (int v = 0; v <= MAXV; v++) begin
            convert(v / 10, v % 10, 0, w);
        end
        idle(2);

        // Randomized conversions, occasional invalid digits and gaps.
        for (int i = 0; i < 40; i++) begin
            d0 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            d1 = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
            convert(d0, d1, 1, w);
        end
        idle(3);

        // Reset mid-conversion, with a digit still offered on the reset edge.
        send_digit(3, w);
        rst           = 1'b1;
        Digito        = 4'd4;
        Digito_valido = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cuenta", int'(Cuenta), 0);
        check("midrst_error", int'(Error), 0);
        check("midrst_valida", int'(Cuenta_valida), 0);
        check("midrst_listo", int'(Digito_listo), 1);
        rst = 1'b0;
        idle(1);
        convert(0, 5, 0, w);
        idle(3);

        repeat (5) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
